multicycle_ctrl: RTL and testbench

Multicycle main controller for the MyCPU datapath: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback states. It is the issuing end of the conditional-write path: it produces the unconditioned `pcs`, `reg_w`, `mem_w`, `flag_w` and `no_write` requests that the conditional logic then gates with the condition code. It also drives every datapath mux select and enable.

---
 rtl/mycpu_pkg.sv | 41 ++++
 rtl/alu_decoder.sv | 47 ++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared MyCPU controller definitions: FSM states, instruction field codes
// and datapath mux encodings.
package mycpu_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation and flag-write decode for data-processing instructions.
// Only the cmd and S fields are needed here, so the I bit is not passed in.
module alu_decoder
   import mycpu_pkg::*;
(
   input  logic [4:0] funct,
   input  logic       active,
   output logic [1:0] alu_control,
   output logic [1:0] flag_w,
   output logic       is_cmp
);

   logic [3:0] cmd;
   logic       s_bit;
   logic       known;
   logic       arith;

   assign cmd   = funct[4:1];
   assign s_bit = funct[0];

   always_comb begin
      alu_control = ALU_ADD;
      known       = 1'b1;
      arith       = 1'b0;
      flag_w      = '0;
      is_cmp      = 1'b0;
      case (cmd)
         CMD_ADD: arith = 1'b1;
         CMD_SUB,
         CMD_CMP: begin
            alu_control = ALU_SUB;
            arith       = 1'b1;
         end
         CMD_AND: alu_control = ALU_AND;
         CMD_ORR: alu_control = ALU_ORR;
         default: known = 1'b0;
      endcase
      // Outside the execute states the ALU just adds (PC+4, address calc).
      if (active) begin
         flag_w = {s_bit & known, s_bit & arith};
         is_cmp = (cmd == CMD_CMP);
      end else begin
         alu_control = ALU_ADD;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute/memory/
// writeback and issuing unconditioned write requests plus datapath selects.
module multicycle_ctrl
   import mycpu_pkg::*;
#(
   parameter int unsigned ST_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   output logic       pcs,
   output logic       reg_w,
   output logic       mem_w,
   output logic [1:0] flag_w,
   output logic       no_write,
   output logic       next_pc,
   output logic       ir_write,
   output logic       adr_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_control,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src
);

   localparam int unsigned SB = $bits(state_t);

   logic [ST_W-1:0] state_q;
   state_t          state;
   state_t          state_d;
   logic            no_write_q;
   logic            no_write_d;
   logic            alu_active;
   logic            is_cmp;
   logic [1:0]      dec_alu;
   logic [1:0]      dec_flag;

   assign state      = state_t'(state_q[SB-1:0]);
   assign alu_active = (state == S_EXECUTER) || (state == S_EXECUTEI);

   alu_decoder u_alu_decoder (
      .funct       (funct[4:0]),
      .active      (alu_active),
      .alu_control (dec_alu),
      .flag_w      (dec_flag),
      .is_cmp      (is_cmp)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_W'(S_FETCH);
         no_write_q <= 1'b0;
      end else begin
         state_q    <= ST_W'(state_d);
         no_write_q <= no_write_d;
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      no_write_d = no_write_q;
      case (state)
         S_FETCH: begin
            state_d    = S_DECODE;
            no_write_d = 1'b0;
         end
         S_DECODE: begin
            case (op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECUTER,
         S_EXECUTEI: begin
            state_d    = S_ALUWB;
            no_write_d = is_cmp;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pcs        = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      no_write   = 1'b0;
      next_pc    = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      result_src = RES_ALUOUT;
      alu_control = dec_alu;
      flag_w      = dec_flag;
      case (state)
         S_FETCH: begin
            ir_write   = 1'b1;
            next_pc    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
         end
         S_MEMADR:   alu_src_b = SRCB_IMM;
         S_MEMRD:    adr_src   = 1'b1;
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            pcs        = (rd == 4'hF);
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECUTEI: alu_src_b = SRCB_IMM;
         S_ALUWB: begin
            no_write = no_write_q;
            reg_w    = ~no_write_q;
            pcs      = ~no_write_q & (rd == 4'hF);
         end
         S_BRANCH: begin
            alu_src_b  = SRCB_IMM;
            result_src = RES_ALU;
            pcs        = 1'b1;
         end
         default: ;
      endcase
      // Async reset must kill every enable at once; selects already show FETCH.
      if (reset) begin
         pcs      = 1'b0;
         reg_w    = 1'b0;
         mem_w    = 1'b0;
         flag_w   = '0;
         no_write = 1'b0;
         next_pc  = 1'b0;
         ir_write = 1'b0;
      end
   end

   assign imm_src = op;
   assign reg_src = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push per-cycle
// expected output bundles; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       pcs, reg_w, mem_w, no_write, next_pc, ir_write, adr_src, alu_src_a;
   logic [1:0] flag_w, alu_src_b, result_src, alu_control, imm_src, reg_src;

   always #5 clk = ~clk;

   multicycle_ctrl #(.ST_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct       (funct),
      .rd          (rd),
      .pcs         (pcs),
      .reg_w       (reg_w),
      .mem_w       (mem_w),
      .flag_w      (flag_w),
      .no_write    (no_write),
      .next_pc     (next_pc),
      .ir_write    (ir_write),
      .adr_src     (adr_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .result_src  (result_src),
      .alu_control (alu_control),
      .imm_src     (imm_src),
      .reg_src     (reg_src)
   );

   logic [19:0] act;
   assign act = {pcs, reg_w, mem_w, flag_w, no_write, next_pc, ir_write, adr_src,
                 alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src};

   string       name_q[$];
   logic [19:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   function automatic logic [19:0] vec(
      input logic e_pcs, input logic e_rw, input logic e_mw, input logic [1:0] e_fw,
      input logic e_nw, input logic e_np, input logic e_ir, input logic e_adr,
      input logic e_asa, input logic [1:0] e_asb, input logic [1:0] e_rs,
      input logic [1:0] e_ac, input logic [1:0] e_imm, input logic [1:0] e_rsrc);
      return {e_pcs, e_rw, e_mw, e_fw, e_nw, e_np, e_ir, e_adr, e_asa, e_asb,
              e_rs, e_ac, e_imm, e_rsrc};
   endfunction

   task automatic push(input string n, input logic [19:0] v);
      name_q.push_back(n);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
      op    = o;
      funct = f;
      rd    = r;
   endtask

   task automatic fetch_decode(input string tag, input logic [1:0] o, input logic [1:0] rsrc);
      push({tag, "_fetch"},  vec(0, 0, 0, 2'b00, 0, 1, 1, 0, 1, 2'b10, 2'b10, 2'b00, o, rsrc));
      push({tag, "_decode"}, vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, o, rsrc));
   endtask

   task automatic wait_cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         string       n;
         logic [19:0] e;
         n = name_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", n, act, e);
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   initial begin
      issue(2'b00, 6'b000000, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'(act), 32'(vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00)));
      @(posedge clk);
      #1 reset = 1'b0;

      // ADD r1 with S
      issue(2'b00, 6'b001001, 4'h1);
      fetch_decode("add", 2'b00, 2'b00);
      push("add_exr",   vec(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      push("add_aluwb", vec(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      // CMP immediate
      issue(2'b00, 6'b110101, 4'h0);
      fetch_decode("cmp", 2'b00, 2'b00);
      push("cmp_exi",   vec(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
      push("cmp_aluwb", vec(0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      // ADD without S after CMP: no_write must have cleared
      issue(2'b00, 6'b001000, 4'h1);
      fetch_decode("addns", 2'b00, 2'b00);
      push("addns_exr",   vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      push("addns_aluwb", vec(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      // LDR r2
      issue(2'b01, 6'b011001, 4'h2);
      fetch_decode("ldr", 2'b01, 2'b00);
      push("ldr_memadr", vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
      push("ldr_memrd",  vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
      push("ldr_memwb",  vec(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
      wait_cycles(5);

      // STR r3
      issue(2'b01, 6'b011000, 4'h3);
      fetch_decode("str", 2'b01, 2'b10);
      push("str_memadr", vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10));
      push("str_memwr",  vec(0, 0, 1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10));
      wait_cycles(4);

      // Branch
      issue(2'b10, 6'b000000, 4'h0);
      fetch_decode("b", 2'b10, 2'b01);
      push("b_branch", vec(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01));
      wait_cycles(3);

      // ORR to r15
      issue(2'b00, 6'b011000, 4'hF);
      fetch_decode("orr", 2'b00, 2'b00);
      push("orr_exr",   vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
      push("orr_aluwb", vec(1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      // Illegal op
      issue(2'b11, 6'b000000, 4'h0);
      fetch_decode("ill", 2'b11, 2'b00);
      wait_cycles(2);

      // AND with S: only NZ written
      issue(2'b00, 6'b000001, 4'h4);
      fetch_decode("and", 2'b00, 2'b00);
      push("and_exr",   vec(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00));
      push("and_aluwb", vec(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      // Unsupported cmd 0001 with S, immediate: ADD, no flags
      issue(2'b00, 6'b100011, 4'h5);
      fetch_decode("unk", 2'b00, 2'b00);
      push("unk_exi",   vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
      push("unk_aluwb", vec(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      // LDR to r15
      issue(2'b01, 6'b011001, 4'hF);
      fetch_decode("ldrpc", 2'b01, 2'b00);
      push("ldrpc_memadr", vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
      push("ldrpc_memrd",  vec(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
      push("ldrpc_memwb",  vec(1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
      wait_cycles(5);

      // Reset pulsed during MEMWR
      issue(2'b01, 6'b011000, 4'h6);
      fetch_decode("rst", 2'b01, 2'b10);
      push("rst_memadr", vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10));
      wait_cycles(3);
      chk("rst_memwr_mem_w", 32'(mem_w), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_async_mem_w", 32'(mem_w), 32'd0);
      chk("rst_async_bundle", 32'(act), 32'(vec(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10)));
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_release_ir_write", 32'(ir_write), 32'd1);

      issue(2'b00, 6'b001001, 4'h1);
      fetch_decode("post", 2'b00, 2'b00);
      push("post_exr",   vec(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      push("post_aluwb", vec(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      wait_cycles(4);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
